// File: rtl/cell_stream_controller_if.sv
// Pixel-group, cell-buffer and cell-cache signals of the cell stream controller.
// The controller uses the master modport; its neighbours use slave.
interface cell_stream_controller_if #(
  parameter int unsigned FRAME_ROW_CNUM = 30,
  parameter int unsigned FRAME_COL_CNUM = 40,
  parameter int unsigned CELL_ROW_PNUM  = 8,
  parameter int unsigned PG_CELL_NUM    = 4
);
  localparam int unsigned CELL_NUM     = FRAME_ROW_CNUM * FRAME_COL_CNUM;
  localparam int unsigned PGCOL_NUM    = FRAME_COL_CNUM / PG_CELL_NUM;
  localparam int unsigned ROW_ADDR_W   = (FRAME_ROW_CNUM > 1) ? $clog2(FRAME_ROW_CNUM) : 1;
  localparam int unsigned CROW_ADDR_W  = (CELL_ROW_PNUM > 1) ? $clog2(CELL_ROW_PNUM) : 1;
  localparam int unsigned PGCOL_ADDR_W = (PGCOL_NUM > 1) ? $clog2(PGCOL_NUM) : 1;
  localparam int unsigned CELL_ADDR_W  = (CELL_NUM > 1) ? $clog2(CELL_NUM) : 1;
  localparam int unsigned COL_ADDR_W   = (FRAME_COL_CNUM > 1) ? $clog2(FRAME_COL_CNUM) : 1;

  logic                    pgroup_valid_i;
  logic                    pgroup_ready_o;
  logic                    pgroup_wr_en_o;
  logic [ROW_ADDR_W-1:0]   row_addr_o;
  logic [CROW_ADDR_W-1:0]  crow_addr_o;
  logic [PGCOL_ADDR_W-1:0] pgcol_addr_o;
  logic                    cell_wr_valid_o;
  logic                    cell_wr_ready_i;
  logic [CELL_ADDR_W-1:0]  cell_wr_addr_o;
  logic [COL_ADDR_W-1:0]   cell_col_addr_o;
  logic                    cell_fetch_start_o;
  logic                    frame_complete_o;
  logic                    busy_o;

  modport master (
    input  pgroup_valid_i,
    input  cell_wr_ready_i,
    output pgroup_ready_o,
    output pgroup_wr_en_o,
    output row_addr_o,
    output crow_addr_o,
    output pgcol_addr_o,
    output cell_wr_valid_o,
    output cell_wr_addr_o,
    output cell_col_addr_o,
    output cell_fetch_start_o,
    output frame_complete_o,
    output busy_o
  );

  modport slave (
    output pgroup_valid_i,
    output cell_wr_ready_i,
    input  pgroup_ready_o,
    input  pgroup_wr_en_o,
    input  row_addr_o,
    input  crow_addr_o,
    input  pgcol_addr_o,
    input  cell_wr_valid_o,
    input  cell_wr_addr_o,
    input  cell_col_addr_o,
    input  cell_fetch_start_o,
    input  frame_complete_o,
    input  busy_o
  );
endinterface

// File: rtl/cell_stream_controller.sv
// Sequences raster-ordered pixel groups into the cell buffer and streams each
// completed group of cells into the cell cache, with backpressure and frame abort.
module cell_stream_controller #(
  parameter int unsigned FRAME_ROW_CNUM = 30,
  parameter int unsigned FRAME_COL_CNUM = 40,
  parameter int unsigned CELL_ROW_PNUM  = 8,
  parameter int unsigned PG_CELL_NUM    = 4,
  parameter int unsigned QSTART_ROWS    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_abort_i,
  cell_stream_controller_if.master bus
);
  localparam int unsigned CELL_NUM     = FRAME_ROW_CNUM * FRAME_COL_CNUM;
  localparam int unsigned PGCOL_NUM    = FRAME_COL_CNUM / PG_CELL_NUM;
  localparam int unsigned ROW_ADDR_W   = (FRAME_ROW_CNUM > 1) ? $clog2(FRAME_ROW_CNUM) : 1;
  localparam int unsigned CROW_ADDR_W  = (CELL_ROW_PNUM > 1) ? $clog2(CELL_ROW_PNUM) : 1;
  localparam int unsigned PGCOL_ADDR_W = (PGCOL_NUM > 1) ? $clog2(PGCOL_NUM) : 1;
  localparam int unsigned CELL_ADDR_W  = (CELL_NUM > 1) ? $clog2(CELL_NUM) : 1;
  localparam int unsigned COL_ADDR_W   = (FRAME_COL_CNUM > 1) ? $clog2(FRAME_COL_CNUM) : 1;
  localparam int unsigned SC_W         = (PG_CELL_NUM > 1) ? $clog2(PG_CELL_NUM) : 1;

  localparam logic [ROW_ADDR_W-1:0]   ROW_LAST   = ROW_ADDR_W'(FRAME_ROW_CNUM - 1);
  localparam logic [CROW_ADDR_W-1:0]  CROW_LAST  = CROW_ADDR_W'(CELL_ROW_PNUM - 1);
  localparam logic [PGCOL_ADDR_W-1:0] PGCOL_LAST = PGCOL_ADDR_W'(PGCOL_NUM - 1);
  localparam logic [CELL_ADDR_W-1:0]  CELL_LAST  = CELL_ADDR_W'(CELL_NUM - 1);
  localparam logic [CELL_ADDR_W-1:0]  QS_LAST    = CELL_ADDR_W'(QSTART_ROWS * FRAME_COL_CNUM - 1);
  localparam logic [SC_W-1:0]         SC_LAST    = SC_W'(PG_CELL_NUM - 1);

  typedef enum logic {StAccept, StStore} state_e;

  state_e                  state_q, state_d;
  logic [ROW_ADDR_W-1:0]   row_q, row_d;
  logic [CROW_ADDR_W-1:0]  crow_q, crow_d;
  logic [PGCOL_ADDR_W-1:0] pgcol_q, pgcol_d;
  logic [PGCOL_ADDR_W-1:0] base_q, base_d;
  logic [SC_W-1:0]         sc_q, sc_d;
  logic [CELL_ADDR_W-1:0]  cell_addr_q, cell_addr_d;
  logic                    start_q, start_d;
  logic                    done_q, done_d;

  logic pg_ready, cw_valid, pg_hs, cw_hs;

  // State register; abort behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (!rst_n || frame_abort_i) begin
      state_q <= StAccept;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccept: if (pg_hs && crow_q == CROW_LAST) state_d = StStore;
      StStore:  if (cw_hs && sc_q == SC_LAST)     state_d = StAccept;
      default:  state_d = StAccept;
    endcase
  end

  // Abort masks both handshakes in its own cycle.
  always_comb begin
    pg_ready = 1'b0;
    cw_valid = 1'b0;
    unique case (state_q)
      StAccept: pg_ready = ~frame_abort_i;
      StStore:  cw_valid = ~frame_abort_i & rst_n;
      default:  ;
    endcase
  end

  assign pg_hs = pg_ready & bus.pgroup_valid_i & rst_n;
  assign cw_hs = cw_valid & bus.cell_wr_ready_i;

  always_comb begin
    row_d       = row_q;
    crow_d      = crow_q;
    pgcol_d     = pgcol_q;
    base_d      = base_q;
    sc_d        = sc_q;
    cell_addr_d = cell_addr_q;
    start_d     = 1'b0;
    done_d      = 1'b0;
    if (pg_hs) begin
      if (crow_q == CROW_LAST) begin
        base_d = pgcol_q;
        sc_d   = '0;
      end
      if (pgcol_q == PGCOL_LAST) begin
        pgcol_d = '0;
        if (crow_q == CROW_LAST) begin
          crow_d = '0;
          row_d  = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          crow_d = crow_q + 1'b1;
        end
      end else begin
        pgcol_d = pgcol_q + 1'b1;
      end
    end
    if (cw_hs) begin
      sc_d        = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
      cell_addr_d = (cell_addr_q == CELL_LAST) ? '0 : cell_addr_q + 1'b1;
      start_d     = (cell_addr_q == QS_LAST);
      done_d      = (cell_addr_q == CELL_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || frame_abort_i) begin
      row_q       <= '0;
      crow_q      <= '0;
      pgcol_q     <= '0;
      base_q      <= '0;
      sc_q        <= '0;
      cell_addr_q <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      row_q       <= row_d;
      crow_q      <= crow_d;
      pgcol_q     <= pgcol_d;
      base_q      <= base_d;
      sc_q        <= sc_d;
      cell_addr_q <= cell_addr_d;
      start_q     <= start_d;
      done_q      <= done_d;
    end
  end

  assign bus.pgroup_ready_o     = pg_ready;
  assign bus.pgroup_wr_en_o     = pg_hs;
  assign bus.row_addr_o         = row_q;
  assign bus.crow_addr_o        = crow_q;
  assign bus.pgcol_addr_o       = pgcol_q;
  assign bus.cell_wr_valid_o    = cw_valid;
  assign bus.cell_wr_addr_o     = cell_addr_q;
  assign bus.cell_col_addr_o    = COL_ADDR_W'(32'(base_q) * PG_CELL_NUM + 32'(sc_q));
  assign bus.cell_fetch_start_o = start_q;
  assign bus.frame_complete_o   = done_q;
  assign bus.busy_o = (state_q == StStore) | (|row_q) | (|crow_q) | (|pgcol_q) | (|sc_q) |
                      (|cell_addr_q);
endmodule
